// File: rtl/fofb_pkg.sv
// Shared definitions for the fast orbit feedback datapath.
// Default widths, FSM encoding and saturation classification.
package fofb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_t;

  // A W+1 bit difference overflows W bits when its top two bits differ;
  // the sign bit then tells which rail to clamp to.
  function automatic sat_t sat_kind(input logic sgn, input logic msb);
    if (sgn == msb) return SAT_NONE;
    return sgn ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/sat_sub.sv
// Registered signed subtract a-b with saturation to W bits.
// One instance per plane in the orbit error pipeline.
module sat_sub
  import fofb_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_d
);

  logic [W:0]   w_d;
  sat_t         w_k;
  logic [W-1:0] r_d;

  assign w_d = {i_a[W-1], i_a} - {i_b[W-1], i_b};
  assign w_k = sat_kind(w_d[W], w_d[W-1]);
  assign o_d = r_d;

  // Clamp overflowed differences to the nearest signed rail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
    end else begin
      unique case (w_k)
        SAT_POS: r_d <= {1'b0, {(W-1){1'b1}}};
        SAT_NEG: r_d <= {1'b1, {(W-1){1'b0}}};
        default: r_d <= w_d[W-1:0];
      endcase
    end
  end

endmodule

// File: rtl/bpm_orbit_err.sv
// Per-BPM orbit error: walks position/reference BRAMs, subtracts,
// saturates, masks and streams errors with peak and trip results.
module bpm_orbit_err
  import fofb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   bpm_count,
  input  logic [DATA_W-2:0] err_limit,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] pos_x,
  input  logic [DATA_W-1:0] pos_y,
  input  logic [DATA_W-1:0] ref_x,
  input  logic [DATA_W-1:0] ref_y,
  input  logic              bpm_en,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_x,
  output logic [DATA_W-1:0] err_y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-2:0] peak_abs,
  output logic              trip,
  output logic [15:0]       overrun_cnt
);

  localparam int PL = RD_LAT + 2;
  localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            r_state;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   w_n;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-2:0] r_peak;
  logic              r_trip;
  logic [DATA_W-2:0] r_acc_pk;
  logic              r_acc_tr;
  logic [DATA_W-2:0] w_pk_nx;
  logic              w_tr_nx;
  logic [PL-1:0]     r_vpipe;
  logic [ADDR_W-1:0] r_apipe [PL];
  logic              w_issue;
  logic              r_en_d;
  logic [DATA_W-1:0] w_sx;
  logic [DATA_W-1:0] w_sy;
  logic [DATA_W-1:0] w_nx;
  logic [DATA_W-1:0] w_ny;
  logic [DATA_W-2:0] w_ax;
  logic [DATA_W-2:0] w_ay;
  logic [DATA_W-1:0] r_ex;
  logic [DATA_W-1:0] r_ey;
  logic [DATA_W-2:0] r_ax;
  logic [DATA_W-2:0] r_ay;
  logic [DATA_W-2:0] w_hit;
  logic              w_cnt;
  logic [15:0]       r_ovr;

  sat_sub #(.W(DATA_W)) u_sat_x (
    .clk   (clk),
    .reset (reset),
    .i_a   (pos_x),
    .i_b   (ref_x),
    .o_d   (w_sx)
  );

  sat_sub #(.W(DATA_W)) u_sat_y (
    .clk   (clk),
    .reset (reset),
    .i_a   (pos_y),
    .i_b   (ref_y),
    .o_d   (w_sy)
  );

  assign w_issue = (r_state == S_READ);
  assign w_n     = (bpm_count > N_MAX) ? N_MAX : bpm_count;

  // The most negative value has no positive twin; pin it to max.
  assign w_nx = -w_sx;
  assign w_ny = -w_sy;
  assign w_ax = (w_sx == S_MIN) ? '1 :
                (w_sx[DATA_W-1] ? w_nx[DATA_W-2:0] : w_sx[DATA_W-2:0]);
  assign w_ay = (w_sy == S_MIN) ? '1 :
                (w_sy[DATA_W-1] ? w_ny[DATA_W-2:0] : w_sy[DATA_W-2:0]);

  // Masked entries carry zero magnitude, so they never raise peak or trip.
  assign w_hit   = (r_ax > r_ay) ? r_ax : r_ay;
  assign w_cnt   = r_vpipe[PL-1];
  assign w_pk_nx = (w_cnt && (w_hit > r_acc_pk)) ? w_hit : r_acc_pk;
  assign w_tr_nx = r_acc_tr | (w_cnt & (w_hit > err_limit));

  assign rd_addr     = r_addr;
  assign err_valid   = r_vpipe[PL-1];
  assign err_addr    = r_apipe[PL-1];
  assign err_x       = r_ex;
  assign err_y       = r_ey;
  assign busy        = r_busy;
  assign done        = r_done;
  assign peak_abs    = r_peak;
  assign trip        = r_trip;
  assign overrun_cnt = r_ovr;

  // Frame sequencer: address walk, drain, result publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_peak   <= '0;
      r_trip   <= 1'b0;
      r_acc_pk <= '0;
      r_acc_tr <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_acc_pk <= w_pk_nx;
      r_acc_tr <= w_tr_nx;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n      <= w_n;
            r_addr   <= '0;
            r_acc_pk <= '0;
            r_acc_tr <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (w_n == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if ({1'b0, r_addr} == r_n - (ADDR_W+1)'(1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_vpipe[RD_LAT-1:0] == '0) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_peak  <= w_pk_nx;
          r_trip  <= w_tr_nx;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid/address delay line plus mask and magnitude stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vpipe <= '0;
      for (int k = 0; k < PL; k++) r_apipe[k] <= '0;
      r_en_d  <= 1'b0;
      r_ex    <= '0;
      r_ey    <= '0;
      r_ax    <= '0;
      r_ay    <= '0;
    end else begin
      r_vpipe    <= {r_vpipe[PL-2:0], w_issue};
      r_apipe[0] <= r_addr;
      for (int k = 1; k < PL; k++) r_apipe[k] <= r_apipe[k-1];
      r_en_d <= bpm_en;
      r_ex   <= r_en_d ? w_sx : '0;
      r_ey   <= r_en_d ? w_sy : '0;
      r_ax   <= r_en_d ? w_ax : '0;
      r_ay   <= r_en_d ? w_ay : '0;
    end
  end

  // Count start pulses that arrive while a frame is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr <= '0;
    end else if (start && (r_state != S_IDLE) && (r_ovr != '1)) begin
      r_ovr <= r_ovr + 16'd1;
    end
  end

endmodule

// File: tb/tb_bpm_orbit_err.sv
// Randomized bench for bpm_orbit_err against an arithmetic frame model.
// BRAMs are modelled as arrays behind an RD_LAT register pipe.
module tb_bpm_orbit_err;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   bpm_count = '0;
  logic [DW-2:0] err_limit = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] pos_x, pos_y, ref_x, ref_y;
  logic          bpm_en;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_x, err_y;
  logic          busy, done;
  logic [DW-2:0] peak_abs;
  logic          trip;
  logic [15:0]   overrun_cnt;

  bpm_orbit_err #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bpm_count   (bpm_count),
    .err_limit   (err_limit),
    .rd_addr     (rd_addr),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .ref_x       (ref_x),
    .ref_y       (ref_y),
    .bpm_en      (bpm_en),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_x       (err_x),
    .err_y       (err_y),
    .busy        (busy),
    .done        (done),
    .peak_abs    (peak_abs),
    .trip        (trip),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] m_px [512];
  logic [DW-1:0] m_py [512];
  logic [DW-1:0] m_rx [512];
  logic [DW-1:0] m_ry [512];
  logic          m_en [512];

  logic [4*DW:0] q [RL];
  always @(posedge clk) begin
    q[0] <= {m_en[rd_addr], m_px[rd_addr], m_py[rd_addr],
             m_rx[rd_addr], m_ry[rd_addr]};
    for (int k = 1; k < RL; k++) q[k] <= q[k-1];
  end
  assign {bpm_en, pos_x, pos_y, ref_x, ref_y} = q[RL-1];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int            a;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } ent_t;

  ent_t    expq [$];
  ent_t    e;
  int      t0 = 0;
  int      vcnt = 0;
  longint  prev_pk = 0;
  bit      prev_tr = 0;

  function automatic longint satv(input longint d);
    if (d > 64'sd2147483647) return 64'sd2147483647;
    if (d < -64'sd2147483648) return -64'sd2147483648;
    return d;
  endfunction

  function automatic longint absv(input longint v);
    if (v == -64'sd2147483648) return 64'sd2147483647;
    return (v < 0) ? -v : v;
  endfunction

  always @(negedge clk) begin
    if (!reset && err_valid) begin
      if (expq.size() == 0) begin
        chk("extra_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("err_addr", err_addr, e.a);
        chk("err_x", err_x, e.x);
        chk("err_y", err_y, e.y);
        chk("valid_cyc", cyc, t0 + RL + 3 + vcnt);
      end
      vcnt++;
    end
  end

  task automatic run_frame(input int cnt, input int ovr_at);
    int     n;
    longint ex, ey, pk, lim;
    bit     tr, got;
    int     exp_done;
    n   = (cnt > 512) ? 512 : cnt;
    lim = longint'(err_limit);
    pk  = 0;
    tr  = 0;
    expq.delete();
    vcnt = 0;
    for (int i = 0; i < n; i++) begin
      ex = 0;
      ey = 0;
      if (m_en[i]) begin
        ex = satv(longint'($signed(m_px[i])) - longint'($signed(m_rx[i])));
        ey = satv(longint'($signed(m_py[i])) - longint'($signed(m_ry[i])));
      end
      expq.push_back('{i, ex[DW-1:0], ey[DW-1:0]});
      if (absv(ex) > pk) pk = absv(ex);
      if (absv(ey) > pk) pk = absv(ey);
      if (absv(ex) > lim || absv(ey) > lim) tr = 1;
    end
    @(posedge clk); #1;
    bpm_count = cnt[AW:0];
    start = 1'b1;
    t0 = cyc;
    exp_done = (n == 0) ? t0 + 2 : t0 + n + RL + 3;
    got = 0;
    for (int k = 1; k < 1200 && !got; k++) begin
      @(posedge clk); #1;
      start = (k == ovr_at);
      bpm_count = (AW+1)'($urandom);
      if (k == 1) begin
        chk("busy_on", busy, 1);
        chk("rd_addr0", rd_addr, 0);
        chk("peak_hold", peak_abs, prev_pk);
        chk("trip_hold", trip, prev_tr);
      end
      if (done) begin
        got = 1;
        chk("done_cyc", cyc, exp_done);
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("peak", peak_abs, pk);
    chk("trip", trip, tr);
    chk("nvalid", vcnt, n);
    chk("missing", expq.size(), 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    prev_pk = pk;
    prev_tr = tr;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        m_px[i] = $urandom;
        m_py[i] = $urandom;
        m_rx[i] = $urandom;
        m_ry[i] = $urandom;
      end else begin
        m_px[i] = DW'($urandom_range(0, 4000)) - 32'd2000;
        m_py[i] = DW'($urandom_range(0, 4000)) - 32'd2000;
        m_rx[i] = DW'($urandom_range(0, 400)) - 32'd200;
        m_ry[i] = DW'($urandom_range(0, 400)) - 32'd200;
      end
      m_en[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", err_valid, 0);
    chk("rst_addr", err_addr, 0);
    chk("rst_err_x", err_x, 0);
    chk("rst_err_y", err_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_peak", peak_abs, 0);
    chk("rst_trip", trip, 0);
    chk("rst_ovr", overrun_cnt, 0);
  endtask

  int seen;

  initial begin
    for (int i = 0; i < 512; i++) begin
      m_px[i] = '0; m_py[i] = '0; m_rx[i] = '0; m_ry[i] = '0;
      m_en[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state();

    err_limit = 31'd100000;
    m_px[0] = 100;  m_px[1] = -50; m_px[2] = 0; m_px[3] = 7;
    m_rx[0] = 0;    m_rx[1] = 0;   m_rx[2] = 0; m_rx[3] = 10;
    run_frame(4, -1);

    m_px[0] = 32'h7FFF_FFFF; m_rx[0] = 32'hFFFF_FFFF;
    m_px[1] = 32'h8000_0000; m_rx[1] = 32'd1;
    run_frame(2, -1);

    err_limit = 31'd1000;
    m_px[0] = 1001; m_rx[0] = 0; m_py[0] = 0; m_ry[0] = 0; m_en[0] = 1;
    run_frame(1, -1);
    m_en[0] = 0;
    run_frame(1, -1);
    m_en[0] = 1; m_px[0] = 1000;
    run_frame(1, -1);
    m_py[0] = -32'd1001;
    run_frame(1, -1);

    fill_random(10);
    run_frame(10, 3);
    chk("overrun_cnt", overrun_cnt, 1);

    run_frame(0, -1);
    fill_random(512);
    run_frame(600, -1);

    fill_random(10);
    @(posedge clk); #1;
    bpm_count = 10;
    start = 1'b1;
    t0 = cyc;
    expq.delete();
    vcnt = 0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_reset_state();
    prev_pk = 0;
    prev_tr = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    run_frame(10, -1);

    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 40);
      err_limit = DW'($urandom_range(0, 3000)) - 32'd0;
      fill_random(n);
      run_frame(n, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
